// File: rtl/subtr_pipe.sv
// Pipelined multi-word subtractor: diff = a - b - bin, borrow chain split into STAGES slices.
// Optional SUBTR_PIPE_SAT_EN: clamp diff to zero on unsigned underflow.
module subtr_pipe #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             zero,
    output logic             ovf
);

    localparam int unsigned SW  = WIDTH / STAGES;
    localparam int unsigned MSB = WIDTH - 1;
    localparam int unsigned LST = STAGES - 1;

    // Stage registers: valid, finished diff bits, operands carried forward, slice borrow
    logic             r_vld [STAGES];
    logic [WIDTH-1:0] r_d   [STAGES];
    logic [WIDTH-1:0] r_a   [STAGES];
    logic [WIDTH-1:0] r_b   [STAGES];
    logic             r_brw [STAGES];
    logic             r_zero;
    logic             r_ovf;

    logic             w_adv;
    logic             w_src_vld [STAGES];
    logic [WIDTH-1:0] w_src_d   [STAGES];
    logic [WIDTH-1:0] w_src_a   [STAGES];
    logic [WIDTH-1:0] w_src_b   [STAGES];
    logic             w_src_brw [STAGES];
    logic [SW:0]      w_res     [STAGES];
    logic [WIDTH-1:0] w_nd      [STAGES];
    logic             w_nbrw    [STAGES];
    logic [WIDTH-1:0] w_fin_d;
    logic             w_zero;
    logic             w_ovf;

    // Ripple-borrow over one slice; returns {borrow_out, diff}
    function automatic logic [SW:0] slice_sub(input logic [SW-1:0] x,
                                              input logic [SW-1:0] y,
                                              input logic          bi);
        logic [SW-1:0] d;
        logic          bw;
        d  = '0;
        bw = bi;
        for (int unsigned i = 0; i < SW; i++) begin
            d[i] = x[i] ^ y[i] ^ bw;
            bw   = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & bw);
        end
        return {bw, d};
    endfunction

    assign w_adv = ~r_vld[LST] | out_ready;

    always_comb begin
        w_src_vld[0] = in_valid;
        w_src_d[0]   = '0;
        w_src_a[0]   = a;
        w_src_b[0]   = b;
        w_src_brw[0] = bin;
        for (int unsigned k = 1; k < STAGES; k++) begin
            w_src_vld[k] = r_vld[k-1];
            w_src_d[k]   = r_d[k-1];
            w_src_a[k]   = r_a[k-1];
            w_src_b[k]   = r_b[k-1];
            w_src_brw[k] = r_brw[k-1];
        end
        for (int unsigned k = 0; k < STAGES; k++) begin
            w_res[k]             = slice_sub(w_src_a[k][k*SW +: SW], w_src_b[k][k*SW +: SW],
                                             w_src_brw[k]);
            w_nd[k]              = w_src_d[k];
            w_nd[k][k*SW +: SW]  = w_res[k][SW-1:0];
            w_nbrw[k]            = w_res[k][SW];
        end
        // Flags are resolved alongside the final slice so they register with diff
        w_fin_d = w_nd[LST];
        w_ovf   = (w_src_a[LST][MSB] ^ w_src_b[LST][MSB]) & (w_fin_d[MSB] ^ w_src_a[LST][MSB]);
        w_zero  = (w_fin_d == '0);
`ifdef SUBTR_PIPE_SAT_EN
        if (w_nbrw[LST]) begin
            w_fin_d = '0;
            w_zero  = 1'b1;
        end
`endif
    end

    // Whole pipeline shifts together, bubbles included, whenever the output can move
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                r_vld[k] <= 1'b0;
                r_d[k]   <= '0;
                r_a[k]   <= '0;
                r_b[k]   <= '0;
                r_brw[k] <= 1'b0;
            end
            r_zero <= 1'b0;
            r_ovf  <= 1'b0;
        end else if (w_adv) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                r_vld[k] <= w_src_vld[k];
                r_a[k]   <= w_src_a[k];
                r_b[k]   <= w_src_b[k];
                r_brw[k] <= w_nbrw[k];
            end
            for (int unsigned k = 0; k < LST; k++) begin
                r_d[k] <= w_nd[k];
            end
            r_d[LST] <= w_fin_d;
            r_zero   <= w_zero;
            r_ovf    <= w_ovf;
        end
    end

    assign in_ready  = w_adv;
    assign out_valid = r_vld[LST];
    assign diff      = r_d[LST];
    assign bout      = r_brw[LST];
    assign zero      = r_zero;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_subtr_pipe.sv
// Scoreboard bench for subtr_pipe: directed cases, backpressure, reset, random and a 16-bit STAGES sweep.
module tb_subtr_pipe;

`ifdef SUBTR_PIPE_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef struct {
        longint unsigned d;
        bit              bo;
        bit              z;
        bit              ov;
        int              acc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, in_ready, out_valid, out_ready;
    logic [7:0] t_a, t_b, diff;
    logic       t_bin, bout, zero, ovf;

    int   n_pass  = 0;
    int   n_total = 0;
    int   cyc     = 0;
    bit   lat_chk = 1'b0;
    bit   rand_bp = 1'b0;
    bit   hold_or = 1'b0;
    exp_t q[$];

    logic [15:0] sw_a, sw_b;
    logic        sw_bin, sw_valid;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    subtr_pipe #(.WIDTH(8), .STAGES(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(t_a), .b(t_b), .bin(t_bin), .out_valid(out_valid), .out_ready(out_ready),
        .diff(diff), .bout(bout), .zero(zero), .ovf(ovf)
    );

    task automatic chk(input string nm, input longint act, input longint req);
        n_total++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, req);
    endtask

    // Reference: integer arithmetic on the operand values, signed range test for overflow
    function automatic exp_t model(input int unsigned w, input longint unsigned xa,
                                   input longint unsigned xb, input bit xbin);
        exp_t        e;
        longint      full, sa, sb, sd, half;
        longint unsigned m;
        m    = (longint'(1) << w) - 1;
        half = longint'(1) << (w - 1);
        full = longint'(xa) - longint'(xb) - longint'(xbin);
        e.bo = (full < 0);
        e.d  = longint'(full) & m;
        sa   = (longint'(xa) >= half) ? longint'(xa) - 2 * half : longint'(xa);
        sb   = (longint'(xb) >= half) ? longint'(xb) - 2 * half : longint'(xb);
        sd   = sa - sb - longint'(xbin);
        e.ov = (sd >= half) || (sd < -half);
        if (SAT && e.bo) e.d = 0;
        e.z   = (e.d == 0);
        e.acc = 0;
        return e;
    endfunction

    function automatic longint pack_exp(input exp_t e);
        return (e.d << 3) | longint'({e.bo, e.z, e.ov});
    endfunction

    task automatic do_send(input logic [7:0] xa, input logic [7:0] xb, input logic xbin,
                           input exp_t e);
        int w = 0;
        @(negedge clk);
        t_a = xa; t_b = xb; t_bin = xbin; in_valid = 1'b1;
        #1;
        while (!in_ready && w < 100) begin
            @(negedge clk); #1; w++;
        end
        if (!in_ready) chk("accept_timeout", longint'(in_ready), 1);
        else begin
            e.acc = cyc;
            q.push_back(e);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send_k(input logic [7:0] xa, input logic [7:0] xb, input logic xbin,
                          input logic [7:0] d, input bit bo, input bit z, input bit ov);
        exp_t e;
        e.d = longint'(d); e.bo = bo; e.z = z; e.ov = ov; e.acc = 0;
        if (SAT && bo) begin
            e.d = 0; e.z = 1'b1;
        end
        do_send(xa, xb, xbin, e);
    endtask

    task automatic send_r(input logic [7:0] xa, input logic [7:0] xb, input logic xbin);
        do_send(xa, xb, xbin, model(8, longint'(xa), longint'(xb), xbin));
    endtask

    task automatic drain(input int lim);
        int k = 0;
        while (q.size() != 0 && k < lim) begin
            @(posedge clk); k++;
        end
        chk("drain_main", longint'(q.size()), 0);
    endtask

    always @(negedge clk) out_ready = rand_bp ? ($urandom_range(0, 2) != 0) : !hold_or;

    // Monitor: pops on each handshake, checks stability while stalled
    bit     prev_stall = 1'b0;
    longint held       = 0;
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (!rst_n) prev_stall = 1'b0;
        else begin
            if (prev_stall) begin
                chk("hold_valid", longint'(out_valid), 1);
                chk("hold_data", longint'({diff, bout, zero, ovf}), held);
            end
            if (out_valid && !out_ready) begin
                chk("stall_in_ready", longint'(in_ready), 0);
                prev_stall = 1'b1;
                held       = longint'({diff, bout, zero, ovf});
            end else prev_stall = 1'b0;
            if (out_valid && out_ready) begin
                if (q.size() == 0) chk("spurious_out", longint'(q.size()), 1);
                else begin
                    e = q.pop_front();
                    chk("result", longint'({diff, bout, zero, ovf}), pack_exp(e));
                    if (lat_chk) chk("latency", longint'(cyc - e.acc), 2);
                end
            end
        end
    end

    // WIDTH=16 sweep over STAGES in {1,4,16}, consumer always ready
    for (genvar gi = 0; gi < 3; gi++) begin : g_sw
        localparam int unsigned SG = (gi == 0) ? 1 : ((gi == 1) ? 4 : 16);
        logic        s_in_ready, s_out_valid, s_bout, s_zero, s_ovf;
        logic [15:0] s_diff;
        exp_t        q[$];

        subtr_pipe #(.WIDTH(16), .STAGES(SG)) u_sw (
            .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(s_in_ready),
            .a(sw_a), .b(sw_b), .bin(sw_bin), .out_valid(s_out_valid), .out_ready(1'b1),
            .diff(s_diff), .bout(s_bout), .zero(s_zero), .ovf(s_ovf)
        );

        always @(negedge clk) begin
            exp_t e;
            #1;
            if (rst_n && sw_valid && s_in_ready) begin
                e     = model(16, longint'(sw_a), longint'(sw_b), sw_bin);
                e.acc = cyc;
                q.push_back(e);
            end
            #1;
            if (rst_n && s_out_valid) begin
                if (q.size() == 0) chk($sformatf("sw%0d_spurious", SG), longint'(q.size()), 1);
                else begin
                    e = q.pop_front();
                    chk($sformatf("sw%0d_result", SG),
                        longint'({s_diff, s_bout, s_zero, s_ovf}), pack_exp(e));
                    chk($sformatf("sw%0d_latency", SG), longint'(cyc - e.acc), longint'(SG));
                end
            end
        end
    end

    initial begin
        int nv;
        rst_n = 1'b0; in_valid = 1'b1; t_a = 8'h11; t_b = 8'h01; t_bin = 1'b0;
        sw_valid = 1'b0; sw_a = '0; sw_b = '0; sw_bin = 1'b0;
        #7;
        chk("rst_in_ready", longint'(in_ready), 1);
        chk("rst_out_valid", longint'(out_valid), 0);
        chk("rst_outputs", longint'({diff, bout, zero, ovf}), 0);
        #4 in_valid = 1'b0;
        #1 rst_n = 1'b1;

        lat_chk = 1'b1;
        send_k(8'h50, 8'h30, 1'b0, 8'h20, 1'b0, 1'b0, 1'b0);
        send_k(8'h30, 8'h50, 1'b0, 8'hE0, 1'b1, 1'b0, 1'b0);
        send_k(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0);
        send_k(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b1);
        send_k(8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b0, 1'b1);
        send_k(8'h5A, 8'h5A, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        send_k(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0);
        drain(50);
        lat_chk = 1'b0;

        // Six back-to-back operands, consumer stalls four cycles on the first result
        fork
            for (int i = 0; i < 6; i++) send_r(8'($urandom), 8'($urandom), 1'($urandom));
            begin
                int w = 0;
                do begin @(posedge clk); #1; w++; end while (!out_valid && w < 50);
                if (!out_valid) chk("first_result_timeout", longint'(out_valid), 1);
                hold_or = 1'b1;
                repeat (4) @(posedge clk);
                #1 hold_or = 1'b0;
            end
        join
        drain(50);

        // Mid-flight reset discards everything in the pipe
        send_r(8'h33, 8'h22, 1'b0);
        send_r(8'h44, 8'h11, 1'b1);
        rst_n = 1'b0;
        q.delete();
        #1;
        chk("midrst_out_valid", longint'(out_valid), 0);
        chk("midrst_outputs", longint'({diff, bout, zero, ovf}), 0);
        #4 rst_n = 1'b1;
        lat_chk = 1'b1;
        send_k(8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0, 1'b0);
        drain(50);
        lat_chk = 1'b0;

        rand_bp = 1'b1;
        for (int i = 0; i < 200; i++) begin
            repeat ($urandom_range(0, 1)) @(negedge clk);
            send_r(8'($urandom), 8'($urandom), 1'($urandom));
        end
        rand_bp = 1'b0;
        drain(400);

        nv = 0;
        while (nv < 1000) begin
            @(negedge clk);
            sw_a     = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
            sw_b     = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
            sw_bin   = 1'($urandom);
            sw_valid = ($urandom_range(0, 4) != 0);
            if (sw_valid) nv++;
        end
        @(negedge clk) sw_valid = 1'b0;
        repeat (40) @(posedge clk);
        chk("drain_sw1", longint'(g_sw[0].q.size()), 0);
        chk("drain_sw4", longint'(g_sw[1].q.size()), 0);
        chk("drain_sw16", longint'(g_sw[2].q.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
